// File: rtl/serial_uart_tx.sv
`default_nettype none
// =============================================================================
// Module   : serial_uart_tx
// Purpose  : 8N1 UART transmitter fed by a power-of-two write FIFO.
// Revision : 1.0 - initial release
// =============================================================================
module serial_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [7:0]                  data_in,
   input  logic                        wren_in,
   output logic                        ready_out,
   output logic                        tx_out,
   output logic                        busy_out,
   output logic [$clog2(FIFO_DEPTH):0] count_out,
   output logic                        overflow_out
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_TMR_W-1:0]   r_timer;
   logic [c_TMR_W-1:0]   w_timer_nxt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_nxt;
   logic [7:0]           r_shift;
   logic [7:0]           w_shift_nxt;
   logic                 r_tx;
   logic                 w_tx_nxt;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic                 r_overflow;
   logic [7:0]           r_mem [FIFO_DEPTH];

   logic                 w_push;
   logic                 w_pop;
   logic                 w_bit_end;

   assign ready_out    = (r_count != c_FULL);
   assign busy_out     = (r_count != '0) || (r_state != IDLE);
   assign tx_out       = r_tx;
   assign count_out    = r_count;
   assign overflow_out = r_overflow;

   assign w_push    = wren_in && ready_out;
   assign w_bit_end = (r_timer == c_TMR_LAST);

   // Storage carries no reset: entries are only ever read after being written.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_CNT_W'(1);
         end
         if (wren_in && !ready_out) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // tx is computed one step ahead so the line changes on the same edge as the state.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_tx_nxt      = r_tx;
      w_pop         = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nxt      = 1'b1;
            w_timer_nxt   = '0;
            w_bit_idx_nxt = '0;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rd_ptr];
               w_state_nxt = START;
               w_tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_timer_nxt = '0;
               w_state_nxt = DATA;
               w_tx_nxt    = r_shift[0];
            end else begin
               w_timer_nxt = r_timer + c_TMR_W'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_timer_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_nxt = '0;
                  w_state_nxt   = STOP;
                  w_tx_nxt      = 1'b1;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_tx_nxt      = r_shift[1];
               end
            end else begin
               w_timer_nxt = r_timer + c_TMR_W'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_timer_nxt = '0;
               w_state_nxt = IDLE;
               w_tx_nxt    = 1'b1;
            end else begin
               w_timer_nxt = r_timer + c_TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire
